// File: rtl/pcie_s10_cfg_src.sv
// pcie_s10_cfg_src: per-function 32-word config image scanned onto the tl_cfg_* sideband.
// Writes are visible to the scan in the same edge they land (write-first read).
module pcie_s10_cfg_src #(
    parameter int L_TILE      = 0,
    parameter int PF_COUNT    = 1,
    parameter int HOLD_CYCLES = L_TILE ? 8 : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr_en,
    input  logic [1:0]  cfg_wr_func,
    input  logic [4:0]  cfg_wr_addr,
    input  logic [31:0] cfg_wr_data,
    output logic [31:0] tl_cfg_ctl,
    output logic [4:0]  tl_cfg_add,
    output logic [1:0]  tl_cfg_func,
    output logic        scan_start
);
    if (L_TILE < 0 || L_TILE > 1) begin : g_bad_tile
        $error("L_TILE must be 0 or 1");
    end
    if (PF_COUNT < 1 || PF_COUNT > 4) begin : g_bad_pf
        $error("PF_COUNT must be 1..4");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 16) begin : g_bad_hold
        $error("HOLD_CYCLES must be 1..16");
    end

    // Functions at or above PF_COUNT are never written, so their rows stay constant zero.
    logic [31:0] mem_q [4][32];
    logic [31:0] mem_d [4][32];
    logic [3:0]  hold_q, hold_d;
    logic [4:0]  add_q, add_d;
    logic [1:0]  func_q, func_d;
    logic [31:0] tl_cfg_ctl_q, tl_cfg_ctl_d;
    logic [4:0]  tl_cfg_add_q, tl_cfg_add_d;
    logic [1:0]  tl_cfg_func_q, tl_cfg_func_d;
    logic        scan_start_q, scan_start_d;
    logic        wr_ok, hold_wrap, add_wrap, func_wrap;

    always_comb begin
        wr_ok = cfg_wr_en && (32'(cfg_wr_func) < 32'(PF_COUNT));
        mem_d = mem_q;
        if (wr_ok)
            mem_d[cfg_wr_func][cfg_wr_addr] = cfg_wr_data;
        hold_wrap = hold_q == 4'(HOLD_CYCLES - 1);
        add_wrap  = add_q == 5'd31;
        func_wrap = func_q == 2'(PF_COUNT - 1);
        hold_d    = hold_wrap ? 4'd0 : hold_q + 4'd1;
        add_d     = hold_wrap ? add_q + 5'd1 : add_q;
        func_d    = (hold_wrap && add_wrap) ? (func_wrap ? 2'd0 : func_q + 2'd1) : func_q;
        // Counters name the slot loaded into the output registers at this edge.
        tl_cfg_ctl_d  = mem_d[func_q][add_q];
        tl_cfg_add_d  = add_q;
        tl_cfg_func_d = func_q;
        scan_start_d  = hold_q == 4'd0 && add_q == 5'd0 && func_q == 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q         <= '{default: '0};
            hold_q        <= '0;
            add_q         <= '0;
            func_q        <= '0;
            tl_cfg_ctl_q  <= '0;
            tl_cfg_add_q  <= '0;
            tl_cfg_func_q <= '0;
            scan_start_q  <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            hold_q        <= hold_d;
            add_q         <= add_d;
            func_q        <= func_d;
            tl_cfg_ctl_q  <= tl_cfg_ctl_d;
            tl_cfg_add_q  <= tl_cfg_add_d;
            tl_cfg_func_q <= tl_cfg_func_d;
            scan_start_q  <= scan_start_d;
        end
    end

    assign tl_cfg_ctl  = tl_cfg_ctl_q;
    assign tl_cfg_add  = tl_cfg_add_q;
    assign tl_cfg_func = tl_cfg_func_q;
    assign scan_start  = scan_start_q;
endmodule
